// File: rtl/collision_probe.sv
`default_nettype none
// ============================================================================
//  Module   : collision_probe
//  Purpose  : Once per frame tick, probe the tile map around the character
//             and publish four per-direction blocked flags together.
//             Map reads go through an external 1-cycle-latency read port.
//  Options  : COLLISION_MID_PROBE_EN adds two mid-height side probes.
//  Revision : 1.0  initial release
// ============================================================================
module collision_probe #(
    parameter int CHAR_W   = 8,
    parameter int CHAR_H   = 16,
    parameter int MAP_COLS = 20,
    parameter int MAP_ROWS = 15
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       start,
    input  logic [7:0] x_position,
    input  logic [7:0] y_position,
    output logic [8:0] tile_addr,
    input  logic       tile_data,
    output logic       left_blocked,
    output logic       right_blocked,
    output logic       up_blocked,
    output logic       down_blocked,
    output logic       busy,
    output logic       done
);

`ifdef COLLISION_MID_PROBE_EN
    localparam int NUM_PROBES = 10;
    localparam logic [8:0] H_HALF = 9'(CHAR_H / 2);
`else
    localparam int NUM_PROBES = 8;
`endif
    localparam logic [3:0] LAST_PROBE = 4'(NUM_PROBES - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ISSUE  = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;
    localparam logic [1:0] S_UPDATE = 2'd3;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    // Probe offsets in 9-bit two's complement; NEG1 is -1.
    localparam logic [8:0] NEG1   = 9'h1FF;
    localparam logic [8:0] W_M1   = 9'(CHAR_W - 1);
    localparam logic [8:0] W_P    = 9'(CHAR_W);
    localparam logic [8:0] H_M1   = 9'(CHAR_H - 1);
    localparam logic [8:0] H_P    = 9'(CHAR_H);
    localparam logic [8:0] X_LIM  = 9'(MAP_COLS * 8);
    localparam logic [8:0] Y_LIM  = 9'(MAP_ROWS * 8);
    localparam logic [8:0] COLS_C = 9'(MAP_COLS);

    logic [1:0] state_q, state_d;
    logic [7:0] xr_q, yr_q;
    logic [3:0] idx_q;
    logic       pipe_valid_q, pipe_oor_q, pipe_sub_q;
    logic [1:0] pipe_dir_q;
    logic [3:0] acc_q;
    logic [3:0] flags_q;
    logic       done_q, busy_q;

    logic [1:0] probe_dir;
    logic [8:0] dx, dy, px, py;
    logic       y_above, y_below, x_out, oor, sub;
    logic [4:0] row, col;
    logic [8:0] row_base, map_addr;
    logic       result;

    // Probe table: direction tag and pixel offset for the current probe index.
    always_comb begin
        probe_dir = DIR_UP;
        dx        = '0;
        dy        = '0;
        case (idx_q)
            4'd0: begin probe_dir = DIR_UP;    dx = '0;   dy = NEG1; end
            4'd1: begin probe_dir = DIR_UP;    dx = W_M1; dy = NEG1; end
            4'd2: begin probe_dir = DIR_DOWN;  dx = '0;   dy = H_P;  end
            4'd3: begin probe_dir = DIR_DOWN;  dx = W_M1; dy = H_P;  end
            4'd4: begin probe_dir = DIR_LEFT;  dx = NEG1; dy = '0;   end
            4'd5: begin probe_dir = DIR_LEFT;  dx = NEG1; dy = H_M1; end
            4'd6: begin probe_dir = DIR_RIGHT; dx = W_P;  dy = '0;   end
            4'd7: begin probe_dir = DIR_RIGHT; dx = W_P;  dy = H_M1; end
`ifdef COLLISION_MID_PROBE_EN
            4'd8: begin probe_dir = DIR_LEFT;  dx = NEG1; dy = H_HALF; end
            4'd9: begin probe_dir = DIR_RIGHT; dx = W_P;  dy = H_HALF; end
`endif
            default: ;
        endcase
    end

    // Probe coordinate, range classification and map address (shift-add multiply).
    always_comb begin
        px      = {1'b0, xr_q} + dx;
        py      = {1'b0, yr_q} + dy;
        y_above = py[8];
        y_below = !py[8] && (py >= Y_LIM);
        x_out   = px[8] || (px >= X_LIM);
        oor     = y_above || y_below || x_out;
        // Vertical rule wins: above the map is open, everything else off-map is solid.
        sub     = !y_above;
        row     = py[7:3];
        col     = px[7:3];
        row_base = '0;
        for (int b = 0; b < 9; b++) begin
            if (COLS_C[b]) begin
                row_base = row_base + ({4'b0, row} << b);
            end
        end
        map_addr = row_base + {4'b0, col};
    end

    // Result of the probe issued last cycle: real map bit or the substitute.
    always_comb begin
        result = pipe_oor_q ? pipe_sub_q : tile_data;
    end

    // FSM state register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_ISSUE;
            S_ISSUE:  if (idx_q == LAST_PROBE) state_d = S_DRAIN;
            S_DRAIN:  state_d = S_UPDATE;
            S_UPDATE: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // FSM outputs: only in-range probes present a real address.
    always_comb begin
        tile_addr = '0;
        if (state_q == S_ISSUE && !oor) begin
            tile_addr = map_addr;
        end
    end

    // Datapath: latch position, step probes, pipeline tags, accumulate, publish.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            xr_q         <= '0;
            yr_q         <= '0;
            idx_q        <= '0;
            pipe_valid_q <= 1'b0;
            pipe_oor_q   <= 1'b0;
            pipe_sub_q   <= 1'b0;
            pipe_dir_q   <= '0;
            acc_q        <= '0;
            flags_q      <= '0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            pipe_valid_q <= (state_q == S_ISSUE);
            pipe_oor_q   <= oor;
            pipe_sub_q   <= sub;
            pipe_dir_q   <= probe_dir;
            done_q       <= (state_q == S_UPDATE);

            if (state_q == S_IDLE) begin
                busy_q <= start;
                if (start) begin
                    xr_q  <= x_position;
                    yr_q  <= y_position;
                    idx_q <= '0;
                    acc_q <= '0;
                end
            end else begin
                busy_q <= 1'b1;
                if (state_q == S_ISSUE) begin
                    idx_q <= idx_q + 4'd1;
                end
                if (pipe_valid_q) begin
                    acc_q[pipe_dir_q] <= acc_q[pipe_dir_q] | result;
                end
                if (state_q == S_UPDATE) begin
                    flags_q <= acc_q;
                end
            end
        end
    end

    assign up_blocked    = flags_q[DIR_UP];
    assign down_blocked  = flags_q[DIR_DOWN];
    assign left_blocked  = flags_q[DIR_LEFT];
    assign right_blocked = flags_q[DIR_RIGHT];
    assign busy          = busy_q;
    assign done          = done_q;

endmodule
`default_nettype wire

// File: tb/tb_collision_probe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_collision_probe
//  Purpose  : Self-checking bench for collision_probe with a tile-map memory
//             model, a behavioural reference and directed frame sweeps.
//  Revision : 1.0  initial release
// ============================================================================
module tb_collision_probe;

    localparam int CW = 8;
    localparam int CH = 16;
`ifdef COLLISION_MID_PROBE_EN
    localparam int NP = 10;
`else
    localparam int NP = 8;
`endif
    localparam int LAT = NP + 2;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0;
    logic [7:0] x_position = '0;
    logic [7:0] y_position = '0;
    logic [8:0] tile_addr;
    logic       tile_data;
    logic       left_blocked, right_blocked, up_blocked, down_blocked;
    logic       busy, done;

    logic       mem [0:299];
    int         n_checks = 0;
    int         n_fail = 0;

    wire [3:0] dut_flags = {left_blocked, right_blocked, up_blocked, down_blocked};

    collision_probe dut (
        .clock         (clock),
        .resetn        (resetn),
        .start         (start),
        .x_position    (x_position),
        .y_position    (y_position),
        .tile_addr     (tile_addr),
        .tile_data     (tile_data),
        .left_blocked  (left_blocked),
        .right_blocked (right_blocked),
        .up_blocked    (up_blocked),
        .down_blocked  (down_blocked),
        .busy          (busy),
        .done          (done)
    );

    always #5 clock = ~clock;

    // Synchronous map memory, one cycle of read latency.
    always @(posedge clock) begin
        tile_data <= (tile_addr < 9'd300) ? mem[tile_addr] : 1'b0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference ----------------
    // Probe i for a character at (x,y): direction (0 up,1 down,2 left,3 right) and pixel.
    function automatic void probe_xy(input int i, input int x, input int y,
                                     output int dir, output int px, output int py);
        dir = 0; px = x; py = y;
        case (i)
            0: begin dir = 0; px = x;          py = y - 1;      end
            1: begin dir = 0; px = x + CW - 1; py = y - 1;      end
            2: begin dir = 1; px = x;          py = y + CH;     end
            3: begin dir = 1; px = x + CW - 1; py = y + CH;     end
            4: begin dir = 2; px = x - 1;      py = y;          end
            5: begin dir = 2; px = x - 1;      py = y + CH - 1; end
            6: begin dir = 3; px = x + CW;     py = y;          end
            7: begin dir = 3; px = x + CW;     py = y + CH - 1; end
            8: begin dir = 2; px = x - 1;      py = y + CH / 2; end
            9: begin dir = 3; px = x + CW;     py = y + CH / 2; end
            default: ;
        endcase
    endfunction

    function automatic bit in_map(input int px, input int py);
        return (px >= 0) && (px < 160) && (py >= 0) && (py < 120);
    endfunction

    function automatic int probe_addr(input int px, input int py);
        return in_map(px, py) ? (py / 8) * 20 + (px / 8) : 0;
    endfunction

    function automatic bit probe_hit(input int px, input int py);
        if (py < 0)    return 1'b0;
        if (py >= 120) return 1'b1;
        if (px < 0 || px >= 160) return 1'b1;
        return mem[(py / 8) * 20 + (px / 8)];
    endfunction

    // Returns {left, right, up, down}.
    function automatic logic [3:0] model_flags(input int x, input int y);
        logic [3:0] f;
        int d, px, py;
        f = '0;
        for (int i = 0; i < NP; i++) begin
            probe_xy(i, x, y, d, px, py);
            if (probe_hit(px, py)) f[d] = 1'b1;
        end
        return {f[2], f[3], f[0], f[1]};
    endfunction

    logic [3:0] e_flags = '0;
    logic       e_done = 1'b0;
    logic       e_busy = 1'b0;
    logic [3:0] m_exp = '0;
    bit         m_run = 1'b0;
    int         m_t = 0;
    int         m_x = 0;
    int         m_y = 0;

    // Reference timeline advanced at every edge, then compared just after it.
    always @(posedge clock) begin
        int d, px, py, e_addr;
        if (!resetn) begin
            e_flags = '0;
            e_done  = 1'b0;
            m_run   = 1'b0;
            m_t     = 0;
        end else begin
            e_done = 1'b0;
            if (m_run) begin
                m_t++;
                if (m_t == LAT) begin
                    e_flags = m_exp;
                    e_done  = 1'b1;
                    m_run   = 1'b0;
                end
            end else if (start) begin
                m_run = 1'b1;
                m_t   = 0;
                m_x   = int'(x_position);
                m_y   = int'(y_position);
                m_exp = model_flags(m_x, m_y);
            end
        end
        e_busy = m_run | e_done;
        e_addr = 0;
        if (m_run && m_t < NP) begin
            probe_xy(m_t, m_x, m_y, d, px, py);
            e_addr = probe_addr(px, py);
        end
        #1;
        chk("cyc_done",  32'(done),      32'(e_done));
        chk("cyc_busy",  32'(busy),      32'(e_busy));
        chk("cyc_flags", 32'(dut_flags), 32'(e_flags));
        chk("cyc_addr",  32'(tile_addr), 32'(e_addr));
    end

    // ---------------- directed stimulus ----------------
    task automatic clear_map();
        for (int i = 0; i < 300; i++) mem[i] = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 40) begin
            @(negedge clock);
            n++;
        end
        chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic run_sweep(input string name, input int x, input int y,
                             input int exp_addr0, input logic [3:0] exp_flags);
        int  cyc;
        bit  found;
        @(negedge clock);
        x_position = 8'(x);
        y_position = 8'(y);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk({name, "_addr0"}, 32'(tile_addr), 32'(exp_addr0));
        cyc = 0;
        found = 1'b0;
        while (!found && cyc < 30) begin
            @(negedge clock);
            cyc++;
            if (done) found = 1'b1;
        end
        chk({name, "_done_seen"}, 32'(found), 32'd1);
        chk({name, "_latency"}, 32'(cyc), 32'(LAT));
        chk({name, "_flags"}, 32'(dut_flags), 32'(exp_flags));
        @(negedge clock);
        chk({name, "_done_1cyc"}, 32'(done), 32'd0);
    endtask

    initial begin
        int dones;
        clear_map();
        repeat (3) @(negedge clock);
        chk("rst_flags", 32'(dut_flags), 32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_done",  32'(done),      32'd0);
        chk("rst_addr",  32'(tile_addr), 32'd0);
        resetn = 1'b1;
        @(negedge clock);

        // Empty map, centre of screen.
        run_sweep("empty", 72, 40, 89, 4'b0000);
        // Solid tile under the feet.
        mem[149] = 1'b1;
        run_sweep("down_tile", 72, 40, 89, 4'b0001);
        clear_map();
        // Solid tile overhead.
        mem[89] = 1'b1;
        run_sweep("up_tile", 72, 40, 89, 4'b0010);
        clear_map();
        // Solid tile to the right.
        mem[110] = 1'b1;
        run_sweep("right_tile", 72, 40, 89, 4'b0100);
        clear_map();
        // Solid tile at the lower-left corner probe.
        mem[128] = 1'b1;
        run_sweep("left_tile", 72, 40, 89, 4'b1000);
        clear_map();
        // Top-left corner: top exempt, left wall.
        run_sweep("top_left", 0, 0, 0, 4'b1000);
        // Bottom-right: floor below, right wall, left probe also below floor.
        run_sweep("bot_right", 152, 110, 279, 4'b1101);
        // Fully below the map.
        run_sweep("floor", 100, 200, 0, 4'b1111);
        // Tile between the two left corner probes.
        mem[28] = 1'b1;
`ifdef COLLISION_MID_PROBE_EN
        run_sweep("mid_left", 72, 4, 9, 4'b1000);
`else
        run_sweep("mid_left", 72, 4, 9, 4'b0000);
`endif
        clear_map();

        // Start while busy is ignored and not queued.
        @(negedge clock);
        x_position = 8'd0; y_position = 8'd0; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        x_position = 8'd152; y_position = 8'd110; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_idle();
        chk("ignored_start_flags", 32'(dut_flags), 32'(4'b1000));

        // Reset in the middle of a sweep that would set down_blocked.
        mem[149] = 1'b1;
        @(negedge clock);
        x_position = 8'd72; y_position = 8'd40; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        @(posedge clock);
        #2;
        resetn = 1'b0;
        #1;
        chk("midrst_flags", 32'(dut_flags), 32'd0);
        chk("midrst_busy",  32'(busy),      32'd0);
        chk("midrst_done",  32'(done),      32'd0);
        dones = 0;
        repeat (3) begin
            @(negedge clock);
            if (done) dones++;
        end
        resetn = 1'b1;
        repeat (12) begin
            @(negedge clock);
            if (done) dones++;
        end
        chk("midrst_no_done", 32'(dones), 32'd0);
        chk("midrst_flags_held", 32'(dut_flags), 32'd0);
        run_sweep("after_rst", 72, 40, 89, 4'b0001);

        // Back-to-back with start held high.
        @(negedge clock);
        x_position = 8'd72; y_position = 8'd40; start = 1'b1;
        dones = 0;
        repeat (2 * LAT + 3) begin
            @(negedge clock);
            if (done) dones++;
        end
        start = 1'b0;
        wait_idle();
        chk("b2b_dones", 32'(dones), 32'd2);
        chk("b2b_flags", 32'(dut_flags), 32'(4'b0001));

        repeat (3) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1);
    end

endmodule
`default_nettype wire
